// File: rtl/dea_frame_decoder.sv
// DEA receive-side decoder: length-prefixed ciphertext frames in, rolling-key XOR plaintext out.
// Optional trailing XOR checksum byte enabled by defining DEA_DEC_CHECKSUM_EN.
module dea_frame_decoder #(
  parameter int unsigned MAX_LEN = 100,
  parameter int unsigned CW      = 8
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Ready,
  output logic       Rx_Ack,
  input  logic       Key_Wr,
  input  logic [1:0] Key_Addr,
  input  logic [7:0] Key_Data,
  input  logic [1:0] Key_Len,
  output logic [7:0] Out_Data,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic       Frame_Done,
  output logic       Len_Err,
  output logic       Chk_Err
);

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_SKIP
`ifdef DEA_DEC_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  state_t          state_q, state_d;
  logic            rx_ack_q, rx_ack_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            frame_done_q, frame_done_d;
  logic            len_err_q, len_err_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      kidx_q, kidx_d;
  logic [2:0][7:0] key_q, key_d;
`ifdef DEA_DEC_CHECKSUM_EN
  logic            chk_err_q, chk_err_d;
  logic [7:0]      csum_q, csum_d;
`endif

  logic       accept;
  logic       last_byte;
  logic [1:0] kidx_eff;
  logic [1:0] kidx_next;
  logic [7:0] key_byte;

  // A shrunk Key_Len can leave kidx out of range; fold it back to slot 0 before use.
  always_comb begin
    accept    = Rx_Ready && !rx_ack_q && ((state_q != S_DATA) || !out_valid_q);
    last_byte = (count_q == CW'(1));
    kidx_eff  = (kidx_q >= Key_Len) ? 2'd0 : kidx_q;
    kidx_next = (({1'b0, kidx_eff} + 3'd1) >= {1'b0, Key_Len}) ? 2'd0 : (kidx_eff + 2'd1);
    key_byte  = 8'h00;
    if (Key_Len != 2'd0) begin
      case (kidx_eff)
        2'd0:    key_byte = key_q[0];
        2'd1:    key_byte = key_q[1];
        2'd2:    key_byte = key_q[2];
        default: key_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    rx_ack_d     = accept || (rx_ack_q && Rx_Ready);
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;
    count_d      = count_q;
    kidx_d       = kidx_q;
    key_d        = key_q;
`ifdef DEA_DEC_CHECKSUM_EN
    chk_err_d    = 1'b0;
    csum_d       = csum_q;
`endif

    if (out_valid_q && Out_Ready) out_valid_d = 1'b0;

    if (Key_Wr) begin
      case (Key_Addr)
        2'd0:    key_d[0] = Key_Data;
        2'd1:    key_d[1] = Key_Data;
        2'd2:    key_d[2] = Key_Data;
        default: ;
      endcase
    end

    if (accept) begin
      case (state_q)
        S_LEN: begin
          if (Rx_Data == 8'h00) begin
            frame_done_d = 1'b1;
          end else if (Rx_Data > MaxLenB) begin
            len_err_d = 1'b1;
            count_d   = CW'(Rx_Data);
            state_d   = S_SKIP;
          end else begin
            count_d = CW'(Rx_Data);
            kidx_d  = 2'd0;
`ifdef DEA_DEC_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          out_data_d  = Rx_Data ^ key_byte;
          out_valid_d = 1'b1;
          kidx_d      = kidx_next;
          count_d     = count_q - CW'(1);
`ifdef DEA_DEC_CHECKSUM_EN
          csum_d      = csum_q ^ Rx_Data;
          if (last_byte) state_d = S_CHK;
`else
          if (last_byte) begin
            frame_done_d = 1'b1;
            state_d      = S_LEN;
          end
`endif
        end
        S_SKIP: begin
          count_d = count_q - CW'(1);
          if (last_byte) state_d = S_LEN;
        end
`ifdef DEA_DEC_CHECKSUM_EN
        S_CHK: begin
          frame_done_d = 1'b1;
          chk_err_d    = (Rx_Data != csum_q);
          state_d      = S_LEN;
        end
`endif
        default: state_d = S_LEN;
      endcase
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Reset) begin
      state_q      <= S_LEN;
      rx_ack_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      count_q      <= '0;
      kidx_q       <= '0;
      key_q        <= '0;
`ifdef DEA_DEC_CHECKSUM_EN
      chk_err_q    <= 1'b0;
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rx_ack_q     <= rx_ack_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
      count_q      <= count_d;
      kidx_q       <= kidx_d;
      key_q        <= key_d;
`ifdef DEA_DEC_CHECKSUM_EN
      chk_err_q    <= chk_err_d;
      csum_q       <= csum_d;
`endif
    end
  end

  assign Rx_Ack     = rx_ack_q;
  assign Out_Valid  = out_valid_q;
  assign Out_Data   = out_data_q;
  assign Frame_Done = frame_done_q;
  assign Len_Err    = len_err_q;
`ifdef DEA_DEC_CHECKSUM_EN
  assign Chk_Err    = chk_err_q;
`else
  assign Chk_Err    = 1'b0;
`endif

endmodule
